// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter that lends one SPI master and its slave-select lines to
// NUM_REQ requesters, sequencing SS setup, transfer, completion/timeout and gap.
module spi_bus_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int SS_WIDTH       = 32,
    parameter int SETUP_CYCLES   = 2,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_REQ-1:0]    req_i,
    input  logic [NUM_REQ*32-1:0] req_wdata_i,
    input  logic [NUM_REQ*3-1:0]  req_nbytes_i,
    input  logic [NUM_REQ*5-1:0]  req_ss_idx_i,
    output logic [NUM_REQ-1:0]    gnt_o,
    output logic [NUM_REQ-1:0]    done_o,
    output logic                  err_o,
    output logic [31:0]           rdata_o,
    output logic                  busy_o,
    output logic                  spi_enable_o,
    output logic [31:0]           spi_wdata_o,
    output logic [2:0]            spi_wbytes_o,
    input  logic [31:0]           spi_rdata_i,
    input  logic [2:0]            spi_rbytes_i,
    output logic [SS_WIDTH-1:0]   spi_ss_o
);

    localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_MAX = (TIMEOUT_CYCLES > SETUP_CYCLES) ?
                             ((TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES) :
                             ((SETUP_CYCLES > GAP_CYCLES) ? SETUP_CYCLES : GAP_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_XFER  = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    localparam logic [SS_WIDTH-1:0] SS_IDLE = {SS_WIDTH{1'b1}};
    localparam logic [SS_WIDTH-1:0] SS_ONE  = {{(SS_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]          state_r;
    logic [PTR_W-1:0]    ptr_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [31:0]         wdata_r;
    logic [2:0]          nbytes_r;
    logic                legal_r;
    logic [NUM_REQ-1:0]  gnt_r;
    logic [NUM_REQ-1:0]  done_r;
    logic                err_r;
    logic [31:0]         rdata_r;
    logic                busy_r;
    logic                en_r;
    logic [SS_WIDTH-1:0] ss_r;

    logic                found_s;
    logic [PTR_W-1:0]    win_s;
    logic [PTR_W-1:0]    nxt_ptr_s;
    logic [31:0]         sel_wdata_s;
    logic [2:0]          sel_nbytes_s;
    logic [4:0]          sel_ss_s;
    logic                legal_s;
    logic                rx_done_s;

    function automatic logic [PTR_W-1:0] rr_index(input logic [PTR_W-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end else begin
            sum = sum;
        end
        return sum[PTR_W-1:0];
    endfunction

    function automatic logic req_legal(input logic [2:0] nbytes, input logic [4:0] ss_idx);
        return (nbytes != 3'd0) && (nbytes <= 3'd4) && ({27'd0, ss_idx} < $unsigned(SS_WIDTH));
    endfunction

    // Round-robin search: first requesting index at or after the pointer.
    always_comb begin
        found_s = 1'b0;
        win_s   = {PTR_W{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found_s && req_i[rr_index(ptr_r, i)]) begin
                found_s = 1'b1;
                win_s   = rr_index(ptr_r, i);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Winner's transaction fields, legality and the following pointer value.
    always_comb begin
        sel_wdata_s  = req_wdata_i[32*win_s +: 32];
        sel_nbytes_s = req_nbytes_i[3*win_s +: 3];
        sel_ss_s     = req_ss_idx_i[5*win_s +: 5];
        legal_s      = req_legal(sel_nbytes_s, sel_ss_s);
        nxt_ptr_s    = (win_s == PTR_W'(NUM_REQ - 1)) ? {PTR_W{1'b0}} : win_s + PTR_W'(1);
        rx_done_s    = (spi_rbytes_i == nbytes_r);
    end

    // Transaction sequencer; every output is a register updated here.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r  <= ST_IDLE;
            ptr_r    <= {PTR_W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            wdata_r  <= 32'd0;
            nbytes_r <= 3'd0;
            legal_r  <= 1'b0;
            gnt_r    <= {NUM_REQ{1'b0}};
            done_r   <= {NUM_REQ{1'b0}};
            err_r    <= 1'b0;
            rdata_r  <= 32'd0;
            busy_r   <= 1'b0;
            en_r     <= 1'b0;
            ss_r     <= SS_IDLE;
        end else begin
            done_r <= {NUM_REQ{1'b0}};
            err_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (found_s) begin
                        gnt_r    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_s;
                        busy_r   <= 1'b1;
                        ptr_r    <= nxt_ptr_s;
                        wdata_r  <= sel_wdata_s;
                        nbytes_r <= sel_nbytes_s;
                        legal_r  <= legal_s;
                        cnt_r    <= {CNT_W{1'b0}};
                        state_r  <= ST_SETUP;
                        // Illegal requests never touch the bus.
                        ss_r     <= legal_s ? ~(SS_ONE << sel_ss_s) : SS_IDLE;
                    end
                end
                ST_SETUP: begin
                    if (!legal_r) begin
                        done_r  <= gnt_r;
                        err_r   <= 1'b1;
                        gnt_r   <= {NUM_REQ{1'b0}};
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= ST_HOLD;
                    end else if (cnt_r == CNT_W'(SETUP_CYCLES - 1)) begin
                        en_r    <= 1'b1;
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= ST_XFER;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_XFER: begin
                    // Completion takes priority over a coincident timeout.
                    if (rx_done_s || (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1))) begin
                        done_r  <= gnt_r;
                        err_r   <= ~rx_done_s;
                        rdata_r <= rx_done_s ? spi_rdata_i : rdata_r;
                        gnt_r   <= {NUM_REQ{1'b0}};
                        en_r    <= 1'b0;
                        ss_r    <= SS_IDLE;
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= ST_HOLD;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (cnt_r == CNT_W'(GAP_CYCLES - 1)) begin
                        busy_r  <= 1'b0;
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    gnt_r   <= {NUM_REQ{1'b0}};
                    en_r    <= 1'b0;
                    ss_r    <= SS_IDLE;
                    busy_r  <= 1'b0;
                    cnt_r   <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign gnt_o        = gnt_r;
    assign done_o       = done_r;
    assign err_o        = err_r;
    assign rdata_o      = rdata_r;
    assign busy_o       = busy_r;
    assign spi_enable_o = en_r;
    assign spi_wdata_o  = wdata_r;
    assign spi_wbytes_o = nbytes_r;
    assign spi_ss_o     = ss_r;

endmodule

// File: doc/spi_bus_arbiter.md
Name: spi_bus_arbiter

Overview:
- Shares one SPIMaster and its slave-select lines between NUM_REQ on-chip requesters, e.g. the CPU-side SPI peripheral plus accelerator DMA engines.
- Arbitrates round-robin and latches the winner's transaction.
- Sequences slave-select setup, SPI enable, completion detection and inter-frame gap, then returns read data and a done/error pulse to the winner.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- SS_WIDTH, 32, number of slave-select lines.
- SETUP_CYCLES, 2, clocks SS is held low before spi_enable_o rises (>=1).
- GAP_CYCLES, 2, clocks SS is held high after a frame before the next grant (>=1).
- TIMEOUT_CYCLES, 4096, maximum clocks in XFER before abort.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- req_i  in  NUM_REQ  request, one bit per requester; held high until that requester's done_o.
- req_wdata_i  in  NUM_REQ*32  write data; requester n uses bits [32n+31:32n].
- req_nbytes_i  in  NUM_REQ*3  bytes to transfer, legal 1..4.
- req_ss_idx_i  in  NUM_REQ*5  index of the slave-select line to drive low.
- gnt_o  out  NUM_REQ  one-hot grant, high from grant until done.
- done_o  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- err_o  out  1  qualifies done_o; 1 = illegal request or timeout.
- rdata_o  out  32  read data captured at completion; held until the next completion.
- busy_o  out  1  high in every state except IDLE.
- spi_enable_o  out  1  to SPIMaster enable_i.
- spi_wdata_o  out  32  to SPIMaster write data.
- spi_wbytes_o  out  3  to SPIMaster write-bytes-valid.
- spi_rdata_i  in  32  from SPIMaster read data.
- spi_rbytes_i  in  3  from SPIMaster read-bytes-valid count.
- spi_ss_o  out  SS_WIDTH  slave selects, active-low.

Behaviour:
- Reset values: gnt_o=0, done_o=0, err_o=0, rdata_o=0, busy_o=0, spi_enable_o=0, spi_wdata_o=0, spi_wbytes_o=0, spi_ss_o=all ones, state=IDLE, round-robin pointer=0.
- Reset mid-transfer aborts at the next edge; no done_o is issued for the aborted transfer.
- All outputs are registered.

State machine (IDLE, SETUP, XFER, HOLD):
- IDLE: if any req_i bit is set, pick the first set bit at or after the pointer, wrapping modulo NUM_REQ.
  - Latch that requester's wdata, nbytes and ss_idx.
  - Next cycle: gnt_o is one-hot, busy_o=1, pointer = winner+1 (wrapping).
- Illegal request (nbytes 0 or >4, or ss_idx>=SS_WIDTH), detected in IDLE:
  - Grant is still issued.
  - The following cycle pulses done_o with err_o=1.
  - Go directly to HOLD; no SS or enable activity.
- SETUP: spi_ss_o[ss_idx]=0, all other bits 1; spi_wdata_o and spi_wbytes_o are driven from the latched values. After SETUP_CYCLES clocks, go to XFER with spi_enable_o=1.
- XFER: counter starts at 0.
  - Normal completion: when spi_rbytes_i == latched nbytes, then on the next edge:
    - rdata_o <= spi_rdata_i;
    - done_o[winner] pulses for one cycle with err_o=0;
    - gnt_o, spi_enable_o and busy-relevant SS are cleared (spi_ss_o=all ones);
    - go to HOLD.
  - Timeout: if the counter reaches TIMEOUT_CYCLES first, take the same exit but with err_o=1 and rdata_o unchanged.
  - If completion and timeout occur in the same cycle, completion wins.
- HOLD: SS all ones and enable low for GAP_CYCLES clocks, then IDLE; busy_o=0 on IDLE entry.
- Request is sampled only in IDLE. A requester lowering req_i before grant is simply not selected. req_i changes after grant are ignored until done.
- Minimum back-to-back spacing is GAP_CYCLES idle-SS clocks plus 1 arbitration clock.
- err_o is valid only in the done_o cycle and is 0 otherwise.

Test Plan:
- Single request: req_i=0001, nbytes=2, ss_idx=5, wdata=0xA5C3; SPIMaster model returns rbytes=2, rdata=0x1234 → spi_ss_o bit 5 low for SETUP_CYCLES before enable; done_o=0001 with err_o=0; rdata_o=0x1234; SS all ones for 2 clocks.
- Round-robin fairness: req_i=1111 held continuously → grants in order 0001, 0010, 0100, 1000, 0001; pointer wraps after requester 3.
- Illegal request: nbytes=0 → done_o pulse with err_o=1; spi_enable_o never rises; spi_ss_o stays all ones. Repeat with ss_idx=31 and SS_WIDTH=16 → same error response.
- Timeout: model never advances rbytes, TIMEOUT_CYCLES=64 → done_o with err_o=1 exactly 64 clocks after XFER entry; rdata_o unchanged; SS released.
- Reset mid-XFER: assert rst_i for 1 cycle → next edge spi_ss_o=all ones, spi_enable_o=0, gnt_o=0; no done_o pulse; a fresh request then starts from pointer 0.
- Withdrawal and 4-byte boundary: req_i[2] pulses high for 1 cycle while requester 0 is busy → never granted. Requester 1 with nbytes=4 completes only when rbytes=4, not at 3.
